// File: rtl/crc_enc_arbiter.sv
// Round-robin front end that time-shares one crc_encoder among NREQ clients.
// A grant loads the winner's data and polynomial into the encoder, which must
// drop crcready within two cycles. The CRC returns tagged with the requester id.
module crc_enc_arbiter #(
  parameter int DATAWIDTH = 10,
  parameter int CRCWIDTH  = 4,
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 31,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*DATAWIDTH-1:0]     req_data,
  input  logic [NREQ*(CRCWIDTH+1)-1:0]  req_poly,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [CRCWIDTH-1:0]           rsp_crc,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          enc_ctrlen,
  output logic [DATAWIDTH-1:0]          enc_datain,
  output logic [CRCWIDTH:0]             enc_genpoly,
  input  logic                          enc_crcready,
  input  logic [CRCWIDTH-1:0]           enc_crcseq
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t state, nstate;

  logic [NREQ-1:0][DATAWIDTH-1:0] data_arr;
  logic [NREQ-1:0][CRCWIDTH:0]    poly_arr;
  logic [NREQ-1:0]                grant;
  logic [IDW-1:0]                 rr_ptr, gid, idx, hold_id;
  logic [DATAWIDTH-1:0]           hold_data;
  logic [CRCWIDTH:0]              hold_poly;
  logic [7:0]                     cnt;
  logic                           found, xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATAWIDTH +: DATAWIDTH];
    assign poly_arr[i] = req_poly[i*(CRCWIDTH+1) +: CRCWIDTH+1];
  end

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx;
        found      = 1'b1;
      end
    end
  end

  // resetn gating keeps req_ready low for the whole reset window.
  assign req_ready   = (resetn && state == IDLE && enc_crcready) ? grant : '0;
  assign xfer        = |(req_valid & req_ready);

  assign enc_ctrlen  = (state == LAUNCH);
  assign enc_datain  = hold_data;
  assign enc_genpoly = hold_poly;
  assign rsp_valid   = (state == RESPOND);
  assign rsp_id      = hold_id;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (xfer) nstate = LAUNCH;
      LAUNCH:    nstate = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!enc_crcready)     nstate = WAIT_DONE;
        else if (cnt == 8'd1)  nstate = RESPOND;
      end
      WAIT_DONE: if (enc_crcready || cnt == TO_LAST) nstate = RESPOND;
      RESPOND:   if (rsp_ready) nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      hold_id   <= '0;
      hold_data <= '0;
      hold_poly <= '0;
      cnt       <= '0;
      rsp_crc   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (xfer) begin
          hold_id   <= gid;
          hold_data <= data_arr[gid];
          hold_poly <= poly_arr[gid];
        end
        LAUNCH: cnt <= '0;
        WAIT_BUSY: begin
          if (!enc_crcready) cnt <= '0;
          else begin
            cnt <= cnt + 8'd1;
            // encoder never acknowledged the load
            if (cnt == 8'd1) begin
              rsp_crc <= '0;
              rsp_err <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + 8'd1;
          if (enc_crcready) begin
            rsp_crc <= enc_crcseq;
            rsp_err <= 1'b0;
          end else if (cnt == TO_LAST) begin
            rsp_crc <= '0;
            rsp_err <= 1'b1;
          end
        end
        RESPOND: if (rsp_ready)
          rr_ptr <= (hold_id == IDW'(NREQ - 1)) ? '0 : hold_id + IDW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_enc_arbiter.sv
// Bench for crc_enc_arbiter: behavioural encoder, round-robin reference model
// and a response scoreboard fed at grant time and drained by a monitor.
module tb_crc_enc_arbiter;
  localparam int DW = 10, CW = 4, NR = 4, TO = 31, IDW = 2;

  logic clk = 1'b0, resetn = 1'b0;
  logic [NR-1:0]        req_valid = '0, req_ready;
  logic [NR*DW-1:0]     req_data = '0;
  logic [NR*(CW+1)-1:0] req_poly = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0]  rsp_crc;
  logic rsp_err, busy, enc_ctrlen, enc_crcready;
  logic [DW-1:0]  enc_datain;
  logic [CW:0]    enc_genpoly;
  logic [CW-1:0]  enc_crcseq;

  int checks = 0, fails = 0, cyc = 0;
  int mode = 0;  // encoder behaviour: 0 normal, 1 stuck ready, 2 busy 40 cycles

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_enc_arbiter #(.DATAWIDTH(DW), .CRCWIDTH(CW), .NREQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_poly(req_poly), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
    .busy(busy), .enc_ctrlen(enc_ctrlen), .enc_datain(enc_datain),
    .enc_genpoly(enc_genpoly), .enc_crcready(enc_crcready), .enc_crcseq(enc_crcseq));

  // Polynomial long division of data * x^CW.
  function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] d, input logic [CW:0] p);
    logic [DW+CW-1:0] r;
    r = {d, {CW{1'b0}}};
    for (int i = DW+CW-1; i >= CW; i--)
      if (r[i]) r[i -: CW+1] = r[i -: CW+1] ^ p;
    return r[CW-1:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Encoder model: busy for DW cycles after a load, then presents the CRC.
  int ecnt;
  logic [CW-1:0] eseq;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ecnt <= 0;
      eseq <= '0;
    end else if (enc_ctrlen && enc_crcready) begin
      if (mode != 1) ecnt <= (mode == 2) ? 40 : DW;
      eseq <= crc_ref(enc_datain, enc_genpoly);
    end else if (ecnt != 0) ecnt <= ecnt - 1;
  end
  assign enc_crcready = (mode == 1) || (ecnt == 0);
  assign enc_crcseq   = eseq;

  typedef struct {
    int id; logic [CW-1:0] crc; logic err; int lat; int gcyc;
    logic [DW-1:0] data; logic [CW:0] poly;
  } exp_t;

  exp_t sb[$];
  exp_t cur, lastg, e;
  logic in_rsp = 1'b0, pend;
  int mptr = 0, eid, mj;
  logic [NR-1:0] expv, last_xfer = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      sb.delete();
      in_rsp    = 1'b0;
      mptr      = 0;
      last_xfer = '0;
    end else begin
      pend = (sb.size() != 0) || in_rsp;
      chk("busy", busy, pend);
      eid  = -1;
      expv = '0;
      if (!pend && enc_crcready) begin
        for (int k = 0; k < NR; k++) begin
          mj = (mptr + k) % NR;
          if (eid < 0 && req_valid[mj]) eid = mj;
        end
        if (eid >= 0) expv[eid] = 1'b1;
      end
      chk("req_ready", req_ready, expv);
      last_xfer = req_valid & req_ready;
      if (|last_xfer) begin
        e.id   = (eid < 0) ? 0 : eid;
        e.gcyc = cyc;
        e.data = req_data[e.id*DW +: DW];
        e.poly = req_poly[e.id*(CW+1) +: CW+1];
        case (mode)
          1:       begin e.crc = '0; e.err = 1'b1; e.lat = 4; end
          2:       begin e.crc = '0; e.err = 1'b1; e.lat = TO + 3; end
          default: begin e.crc = crc_ref(e.data, e.poly); e.err = 1'b0; e.lat = DW + 3; end
        endcase
        sb.push_back(e);
        lastg = e;
      end
      if (enc_ctrlen) begin
        chk("ctrlen_while_ready", enc_crcready, 1);
        chk("ctrlen_cycle", cyc, lastg.gcyc + 1);
        chk("enc_datain", enc_datain, lastg.data);
        chk("enc_genpoly", enc_genpoly, lastg.poly);
      end
      if (rsp_valid) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            checks++; fails++;
            $display("FAIL rsp_unexpected actual=valid required=none (cycle %0d)", cyc);
          end else begin
            cur    = sb.pop_front();
            in_rsp = 1'b1;
            chk("rsp_latency", cyc - cur.gcyc, cur.lat);
          end
        end
        if (in_rsp) begin
          chk("rsp_id", rsp_id, cur.id);
          chk("rsp_crc", rsp_crc, cur.crc);
          chk("rsp_err", rsp_err, cur.err);
          if (rsp_ready) begin
            mptr   = (cur.id + 1) % NR;
            in_rsp = 1'b0;
          end
        end
      end else if (in_rsp) chk("rsp_valid_held", rsp_valid, 1);
    end
  end

  task automatic set_req(input int i, input logic v);
    req_valid[i] = v;
    req_data[i*DW +: DW] = DW'($urandom);
    req_poly[i*(CW+1) +: CW+1] = {1'b1, CW'($urandom)};
  endtask

  task automatic wait_xfer(input logic [NR-1:0] mask, input int bound, output int id, output int c);
    id = -1;
    c  = 0;
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (|(last_xfer & mask)) begin
        for (int i = 0; i < NR; i++) if (last_xfer[i] && id < 0) id = i;
        c = cyc;
        return;
      end
    end
    checks++; fails++;
    $display("FAIL grant_timeout actual=none required=grant mask=%b", mask);
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(posedge clk); #1;
      if (!in_rsp && sb.size() == 0 && !busy) return;
    end
    checks++; fails++;
    $display("FAIL idle_timeout actual=busy required=idle");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_crc"}, rsp_crc, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_enc_ctrlen"}, enc_ctrlen, 0);
    chk({tag, "_enc_datain"}, enc_datain, 0);
    chk({tag, "_enc_genpoly"}, enc_genpoly, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, c, c1, prev, hs;
    #12;
    chk_zero("reset");
    @(posedge clk); #1 resetn = 1'b1;

    // Single request with the textbook vector.
    req_valid[0] = 1'b1;
    req_data[0 +: DW] = 10'b1101011011;
    req_poly[0 +: CW+1] = 5'b10011;
    wait_xfer(4'b0001, 10, id, c);
    req_valid[0] = 1'b0;
    for (int k = 0; k < 20 && !rsp_valid; k++) begin @(posedge clk); #1; end
    chk("t1_crc_literal", rsp_crc, 4'b1110);
    wait_idle(30);

    // All requesters active: strict rotation, DW+4 spacing.
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      wait_xfer(4'b1111, 30, id, c);
      chk("rr_order", id, k % NR);
      if (k > 0) chk("grant_spacing", c - prev, DW + 4);
      prev = c;
      if (id >= 0) set_req(id, 1'b1);
    end
    req_valid = '0;
    wait_idle(40);

    // Backpressure for 20 cycles, then grant right after the handshake.
    rsp_ready = 1'b0;
    set_req(2, 1'b1);
    wait_xfer(4'b0100, 10, id, c);
    req_valid[2] = 1'b0;
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    for (int k = 0; k < 30 && !rsp_valid; k++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk);
    #1 rsp_ready = 1'b1;
    hs = cyc;
    wait_xfer(4'b0011, 5, id, c);
    chk("grant_after_handshake", c - hs, 2);
    chk("grant_after_bp_id", id, 0);
    req_valid = '0;
    wait_idle(40);

    // Encoder never goes busy.
    mode = 1;
    set_req(1, 1'b1);
    wait_xfer(4'b0010, 10, id, c);
    req_valid[1] = 1'b0;
    wait_idle(20);
    mode = 0;

    // Encoder busy 40 cycles: WAIT_DONE timeout, then no grant until ready.
    mode = 2;
    set_req(3, 1'b1);
    wait_xfer(4'b1000, 10, id, c1);
    req_valid[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1 mode = 0;
    set_req(0, 1'b1);
    wait_xfer(4'b0001, 60, id, c);
    chk("grant_after_encoder_ready", c - c1, 42);
    req_valid[0] = 1'b0;
    wait_idle(30);

    // Reset while waiting on the encoder.
    set_req(2, 1'b1);
    wait_xfer(4'b0100, 10, id, c);
    req_valid[2] = 1'b0;
    set_req(1, 1'b1);
    set_req(3, 1'b1);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    wait_xfer(4'b1010, 10, id, c);
    chk("post_reset_grant", id, 1);
    req_valid = '0;
    wait_idle(30);

    // Requester 1 withdraws before being reached; 3 must win.
    set_req(0, 1'b1);
    wait_xfer(4'b0001, 10, id, c);
    req_valid[0] = 1'b0;
    set_req(1, 1'b1);
    set_req(3, 1'b1);
    repeat (4) @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_xfer(4'b1010, 30, id, c);
    chk("withdrawn_grant", id, 3);
    req_valid = '0;
    wait_idle(30);

    // Random traffic with random backpressure and withdrawals.
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        if (last_xfer[i])                           set_req(i, 1'($urandom_range(0, 1)));
        else if (!req_valid[i])                     begin if ($urandom_range(0, 2) == 0) set_req(i, 1'b1); end
        else if ($urandom_range(0, 19) == 0)        req_valid[i] = 1'b0;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
